// File: rtl/coil_emulator_pkg.sv
// Shared types and helpers for the coil emulator: bridge-state enum, saturating
// ramp/decay arithmetic and parameter legality check.
package coil_emulator_pkg;

  typedef enum logic [2:0] {
    BR_COAST,
    BR_POS,
    BR_NEG,
    BR_BRAKE,
    BR_SHOOT
  } bridge_t;

  // Signed step that clamps at +/-limit; crossing zero is deliberately allowed.
  function automatic int satStep(input int value, input int step, input int limit);
    int sum;
    sum = value + step;
    if (sum > limit) return limit;
    if (sum < -limit) return -limit;
    return sum;
  endfunction

  function automatic int decayToward(input int value, input int step);
    if (value > step) return value - step;
    if (value < -step) return value + step;
    return 0;
  endfunction

  function automatic bit paramsLegal(input int currentW, input int dutyW, input int imax);
    return (dutyW <= currentW - 1) && (imax > 0) && (imax < (1 << (currentW - 1)));
  endfunction

endpackage

// File: rtl/coil_channel.sv
// One emulated coil: bridge decode, current integrator with sticky shoot-through
// fault, PWM duty counter, registered comparator and optional peak tracker.
module coil_channel
  import coil_emulator_pkg::*;
#(
  parameter int CURRENT_W  = 13,
  parameter int DUTY_W     = 12,
  parameter int RISE_STEP  = 4,
  parameter int DECAY_STEP = 1,
  parameter int IMAX       = 4000
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   i_low_1,
  input  logic                   i_high_1,
  input  logic                   i_low_2,
  input  logic                   i_high_2,
  input  logic                   i_polarity_invert,
  input  logic                   i_pwm_ref,
  input  logic                   i_fault_clear,
  input  logic                   i_wrap,
  output logic [CURRENT_W-1:0]   o_current,
  output logic [DUTY_W-1:0]      o_target,
  output logic                   o_cmp_out,
  output logic                   o_fault,
  output logic [CURRENT_W-2:0]   o_peak
);

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  bridge_t                w_bridge;
  int                     w_curInt;
  int                     w_nextInt;
  logic [CURRENT_W-2:0]   w_abs;
  logic [DUTY_W-1:0]      w_highNext;

  logic [CURRENT_W-1:0]   r_current;
  logic                   r_fault;
  logic [DUTY_W-1:0]      r_high;
  logic [DUTY_W-1:0]      r_target;
  logic                   r_cmp;

  // Shoot-through is checked first; with it excluded, POS/NEG need only their two gates.
  always_comb begin
    w_bridge = BR_COAST;
    if ((i_high_1 & i_low_1) | (i_high_2 & i_low_2))
      w_bridge = BR_SHOOT;
    else if (i_high_1 & i_low_2 & ~i_low_1 & ~i_high_2)
      w_bridge = i_polarity_invert ? BR_NEG : BR_POS;
    else if (i_high_2 & i_low_1 & ~i_high_1 & ~i_low_2)
      w_bridge = i_polarity_invert ? BR_POS : BR_NEG;
    else if (i_low_1 & i_low_2)
      w_bridge = BR_BRAKE;
  end

  assign w_curInt = int'($signed(r_current));

  always_comb begin
    w_nextInt = w_curInt;
    case (w_bridge)
      BR_POS:   w_nextInt = satStep(w_curInt, RISE_STEP, IMAX);
      BR_NEG:   w_nextInt = satStep(w_curInt, -RISE_STEP, IMAX);
      BR_BRAKE: w_nextInt = decayToward(w_curInt, DECAY_STEP);
      BR_COAST: w_nextInt = decayToward(w_curInt, 2 * DECAY_STEP);
      default:  w_nextInt = 0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_current <= '0;
      r_fault   <= 1'b0;
    end else if (w_bridge == BR_SHOOT) begin
      r_current <= '0;
      r_fault   <= 1'b1;
    end else if (r_fault) begin
      r_current <= '0;
      if (i_fault_clear) r_fault <= 1'b0;
    end else begin
      r_current <= CURRENT_W'(w_nextInt);
    end
  end

  assign w_highNext = (i_pwm_ref && (r_high != DUTY_MAX)) ? r_high + DUTY_W'(1) : r_high;

  // The wrap-cycle sample belongs to the closing window, so target takes w_highNext.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_high   <= '0;
      r_target <= '0;
    end else if (i_wrap) begin
      r_target <= w_highNext;
      r_high   <= DUTY_W'(i_pwm_ref);
    end else begin
      r_high   <= w_highNext;
    end
  end

  assign w_abs = (CURRENT_W-1)'(r_current[CURRENT_W-1] ? (~r_current + 1'b1) : r_current);

  always_ff @(posedge clock) begin
    if (!resetn) r_cmp <= 1'b1;
    else         r_cmp <= (w_abs >= (CURRENT_W-1)'(r_target));
  end

`ifdef COIL_EMULATOR_PEAK_TRACK_EN
  logic [CURRENT_W-2:0] r_runMax;
  logic [CURRENT_W-2:0] r_peak;
  logic [CURRENT_W-2:0] w_max;

  assign w_max = (w_abs > r_runMax) ? w_abs : r_runMax;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_runMax <= '0;
      r_peak   <= '0;
    end else if (i_wrap) begin
      r_peak   <= w_max;
      r_runMax <= w_abs;
    end else begin
      r_runMax <= w_max;
    end
  end

  assign o_peak = r_peak;
`else
  assign o_peak = '0;
`endif

  assign o_current = r_current;
  assign o_target  = r_target;
  assign o_cmp_out = r_cmp;
  assign o_fault   = r_fault;

endmodule

// File: rtl/coil_emulator.sv
// N-channel H-bridge coil emulator with shared duty-meter window counter.
// Optional peak tracking is enabled by defining COIL_EMULATOR_PEAK_TRACK_EN.
module coil_emulator
  import coil_emulator_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int CURRENT_W  = 13,
  parameter int DUTY_W     = 12,
  parameter int RISE_STEP  = 4,
  parameter int DECAY_STEP = 1,
  parameter int IMAX       = 4000
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [CHANNELS-1:0]               i_low_1,
  input  logic [CHANNELS-1:0]               i_high_1,
  input  logic [CHANNELS-1:0]               i_low_2,
  input  logic [CHANNELS-1:0]               i_high_2,
  input  logic [CHANNELS-1:0]               i_polarity_invert,
  input  logic [CHANNELS-1:0]               i_pwm_ref,
  input  logic                              i_fault_clear,
  output logic [CHANNELS*CURRENT_W-1:0]     o_current,
  output logic [CHANNELS*DUTY_W-1:0]        o_target,
  output logic [CHANNELS-1:0]               o_cmp_out,
  output logic [CHANNELS-1:0]               o_fault,
  output logic [CHANNELS*(CURRENT_W-1)-1:0] o_peak
);

  if (!paramsLegal(CURRENT_W, DUTY_W, IMAX)) begin : gBadParams
    $error("coil_emulator: need DUTY_W <= CURRENT_W-1 and 0 < IMAX < 2**(CURRENT_W-1)");
  end

  logic [DUTY_W-1:0] r_window;
  logic              w_wrap;

  assign w_wrap = &r_window;

  always_ff @(posedge clock) begin
    if (!resetn) r_window <= '0;
    else         r_window <= r_window + 1'b1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : gChannel
    coil_channel #(
      .CURRENT_W  (CURRENT_W),
      .DUTY_W     (DUTY_W),
      .RISE_STEP  (RISE_STEP),
      .DECAY_STEP (DECAY_STEP),
      .IMAX       (IMAX)
    ) uChannel (
      .clock             (clock),
      .resetn            (resetn),
      .i_low_1           (i_low_1[i]),
      .i_high_1          (i_high_1[i]),
      .i_low_2           (i_low_2[i]),
      .i_high_2          (i_high_2[i]),
      .i_polarity_invert (i_polarity_invert[i]),
      .i_pwm_ref         (i_pwm_ref[i]),
      .i_fault_clear     (i_fault_clear),
      .i_wrap            (w_wrap),
      .o_current         (o_current[i*CURRENT_W +: CURRENT_W]),
      .o_target          (o_target[i*DUTY_W +: DUTY_W]),
      .o_cmp_out         (o_cmp_out[i]),
      .o_fault           (o_fault[i]),
      .o_peak            (o_peak[i*(CURRENT_W-1) +: (CURRENT_W-1)])
    );
  end

endmodule

// File: tb/tb_coil_emulator.sv
// Scoreboard bench for coil_emulator: directed test-plan phases plus random gates,
// checked every cycle against an integer reference model of the coil rules.
module tb_coil_emulator;

  localparam int CH    = 2;
  localparam int CW    = 13;
  localparam int DW    = 12;
  localparam int RISE  = 4;
  localparam int DECAY = 1;
  localparam int IMAX  = 4000;
  localparam int WIN   = 4096;

  localparam int M_COAST = 0;
  localparam int M_POS   = 1;
  localparam int M_NEG   = 2;
  localparam int M_BRAKE = 3;
  localparam int M_SHOOT = 4;

  logic                     clock;
  logic                     resetn;
  logic [CH-1:0]            low1, high1, low2, high2, polInv, pwmRef;
  logic                     faultClear;
  logic [CH*CW-1:0]         current;
  logic [CH*DW-1:0]         target;
  logic [CH-1:0]            cmpOut;
  logic [CH-1:0]            fault;
  logic [CH*(CW-1)-1:0]     peak;

  coil_emulator #(
    .CHANNELS(CH), .CURRENT_W(CW), .DUTY_W(DW),
    .RISE_STEP(RISE), .DECAY_STEP(DECAY), .IMAX(IMAX)
  ) dut (
    .clock             (clock),
    .resetn            (resetn),
    .i_low_1           (low1),
    .i_high_1          (high1),
    .i_low_2           (low2),
    .i_high_2          (high2),
    .i_polarity_invert (polInv),
    .i_pwm_ref         (pwmRef),
    .i_fault_clear     (faultClear),
    .o_current         (current),
    .o_target          (target),
    .o_cmp_out         (cmpOut),
    .o_fault           (fault),
    .o_peak            (peak)
  );

  typedef struct {
    int                   cycle;
    logic [CH*CW-1:0]     current;
    logic [CH*DW-1:0]     target;
    logic [CH-1:0]        cmp;
    logic [CH-1:0]        fault;
    logic [CH*(CW-1)-1:0] peak;
  } expect_t;

  expect_t sbQueue[$];
  expect_t monE;
  int total = 0;
  int bad = 0;
  int cycleNo = 0;

  int gMode[CH];
  logic [CH-1:0] gInv;
  logic [CH-1:0] gPwm;
  logic gClr;
  logic gResetn;

  int mCur[CH], mFault[CH], mHigh[CH], mTarget[CH], mCmp[CH], mRun[CH], mPeak[CH];
  int mWin;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: state after the coming edge, computed from the coil rules directly.
  task automatic modelStep();
    expect_t e;
    int absOld, cnt, mx, dir, step;
    bit wrap, shoot, pos, neg, brake;
    if (!gResetn) begin
      for (int c = 0; c < CH; c++) begin
        mCur[c] = 0; mFault[c] = 0; mHigh[c] = 0; mTarget[c] = 0;
        mCmp[c] = 1; mRun[c] = 0; mPeak[c] = 0;
      end
      mWin = 0;
    end else begin
      wrap = (mWin == WIN - 1);
      for (int c = 0; c < CH; c++) begin
        absOld = iabs(mCur[c]);
        mCmp[c] = (absOld >= mTarget[c]) ? 1 : 0;
        cnt = mHigh[c] + int'(pwmRef[c]);
        if (cnt > WIN - 1) cnt = WIN - 1;
        mx = (absOld > mRun[c]) ? absOld : mRun[c];
        if (wrap) begin
          mTarget[c] = cnt; mHigh[c] = int'(pwmRef[c]);
          mPeak[c] = mx; mRun[c] = absOld;
        end else begin
          mHigh[c] = cnt; mRun[c] = mx;
        end
        shoot = (high1[c] && low1[c]) || (high2[c] && low2[c]);
        pos   = high1[c] && low2[c] && !low1[c] && !high2[c];
        neg   = high2[c] && low1[c] && !high1[c] && !low2[c];
        brake = low1[c] && low2[c];
        if (shoot) begin
          mFault[c] = 1; mCur[c] = 0;
        end else if (mFault[c] != 0) begin
          if (gClr) mFault[c] = 0;
          mCur[c] = 0;
        end else if (pos || neg) begin
          dir = pos ? 1 : -1;
          if (polInv[c]) dir = -dir;
          mCur[c] = mCur[c] + dir * RISE;
          if (mCur[c] > IMAX) mCur[c] = IMAX;
          if (mCur[c] < -IMAX) mCur[c] = -IMAX;
        end else begin
          step = brake ? DECAY : 2 * DECAY;
          if (iabs(mCur[c]) <= step) mCur[c] = 0;
          else mCur[c] = mCur[c] - ((mCur[c] > 0) ? step : -step);
        end
      end
      mWin = (mWin + 1) % WIN;
    end
    e.cycle = cycleNo;
    e.peak = '0;
    for (int c = 0; c < CH; c++) begin
      e.current[c*CW +: CW] = CW'(mCur[c]);
      e.target[c*DW +: DW]  = DW'(mTarget[c]);
      e.cmp[c]   = (mCmp[c] != 0);
      e.fault[c] = (mFault[c] != 0);
`ifdef COIL_EMULATOR_PEAK_TRACK_EN
      e.peak[c*(CW-1) +: (CW-1)] = (CW-1)'(mPeak[c]);
`endif
    end
    sbQueue.push_back(e);
  endtask

  // pwmPattern: 0 = gPwm, 1 = high for first 1024 cycles of each window, 2 = random.
  task automatic applyStimulus(input int pwmPattern);
    @(negedge clock);
    cycleNo++;
    resetn     = gResetn;
    faultClear = gClr;
    polInv     = gInv;
    for (int c = 0; c < CH; c++) begin
      low1[c]  = (gMode[c] == M_NEG) || (gMode[c] == M_BRAKE) || (gMode[c] == M_SHOOT);
      high1[c] = (gMode[c] == M_POS) || (gMode[c] == M_SHOOT);
      low2[c]  = (gMode[c] == M_POS) || (gMode[c] == M_BRAKE);
      high2[c] = (gMode[c] == M_NEG);
      case (pwmPattern)
        1:       pwmRef[c] = (mWin < 1024);
        2:       pwmRef[c] = ($urandom_range(0, 3) != 0);
        default: pwmRef[c] = gPwm[c];
      endcase
    end
    modelStep();
  endtask

  task automatic runCycles(input int n, input int pwmPattern);
    for (int k = 0; k < n; k++) applyStimulus(pwmPattern);
  endtask

  task automatic checkOutput(input expect_t e);
    total++;
    if (current !== e.current || target !== e.target || cmpOut !== e.cmp ||
        fault !== e.fault || peak !== e.peak) begin
      bad++;
      $display("[TB] FAIL outputs cycle=%0d got cur=%h tgt=%h cmp=%b flt=%b pk=%h want cur=%h tgt=%h cmp=%b flt=%b pk=%h",
               e.cycle, current, target, cmpOut, fault, peak,
               e.current, e.target, e.cmp, e.fault, e.peak);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (sbQueue.size() > 0) begin
      monE = sbQueue.pop_front();
      checkOutput(monE);
    end
  end

  initial begin
    int pick;
    resetn = 1'b0; faultClear = 1'b0;
    low1 = '0; high1 = '0; low2 = '0; high2 = '0; polInv = '0; pwmRef = '0;
    for (int c = 0; c < CH; c++) gMode[c] = M_COAST;
    gInv = '0; gPwm = '0; gClr = 1'b0; gResetn = 1'b0;
    mWin = 0;

    gResetn = 1'b0; runCycles(3, 0); gResetn = 1'b1;

    // Ramp, saturation, brake and coast decay on ch0 only.
    gMode[0] = M_POS;   runCycles(100, 0);
    runCycles(1000, 0);
    gMode[0] = M_BRAKE; runCycles(400, 0);
    gMode[0] = M_COAST; runCycles(2000, 0);

    // Shoot-through fault, clear, and clear losing to a simultaneous shoot.
    gMode[0] = M_POS;   runCycles(100, 0);
    gMode[0] = M_SHOOT; runCycles(1, 0);
    gMode[0] = M_POS;   runCycles(10, 0);
    gMode[0] = M_COAST; gClr = 1'b1; runCycles(1, 0); gClr = 1'b0;
    gMode[0] = M_POS;   runCycles(20, 0);
    gMode[0] = M_SHOOT; gClr = 1'b1; runCycles(1, 0); gClr = 1'b0;
    gMode[0] = M_POS;   runCycles(5, 0);
    gMode[0] = M_COAST; gClr = 1'b1; runCycles(1, 0); gClr = 1'b0;

    // Quarter-duty windows; comparator around target 1024; inverted polarity on ch1.
    gResetn = 1'b0; runCycles(2, 0); gResetn = 1'b1;
    gInv[1] = 1'b1; gMode[1] = M_POS; runCycles(300, 1);
    gMode[1] = M_COAST; runCycles(WIN - 300 + 100, 1);
    gMode[0] = M_POS;   runCycles(100, 1);
    gMode[0] = M_NEG;   runCycles(375, 1);
    gMode[0] = M_COAST; runCycles(3700, 1);
    gInv = '0;

    // Constant-high duty, then reset mid-window.
    gPwm = '1; runCycles(WIN + 10, 0);
    runCycles(2000, 0);
    gResetn = 1'b0; runCycles(1, 0); gResetn = 1'b1;
    runCycles(WIN + 100, 0);
    gPwm = '0;

    // Random gates, polarity, pwm and occasional clears.
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          pick = $urandom_range(0, 99);
          gMode[c] = (pick < 40) ? M_POS : (pick < 75) ? M_NEG :
                     (pick < 85) ? M_BRAKE : (pick < 97) ? M_COAST : M_SHOOT;
        end
        if ($urandom_range(0, 499) == 0) gInv[c] = ~gInv[c];
      end
      gClr = ($urandom_range(0, 9) == 0);
      applyStimulus(2);
    end
    gClr = 1'b1; for (int c = 0; c < CH; c++) gMode[c] = M_COAST;
    runCycles(1, 0);
    gClr = 1'b0; gInv = '0;

    // Peak window: ramp to 800 and decay back to 0 inside one window.
    gResetn = 1'b0; runCycles(2, 0); gResetn = 1'b1;
    gMode[0] = M_POS;   runCycles(200, 0);
    gMode[0] = M_COAST; runCycles(WIN - 200 + 20, 0);

    for (int k = 0; k < 5 && sbQueue.size() > 0; k++) @(posedge clock);
    #2;
    if (sbQueue.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sbQueue.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coil_emulator.md
Name: coil_emulator

Overview:
Parametrised N-channel behavioural model of H-bridge stepper coils plus PWM-reference duty meter and current comparator. It closes the loop around the microstepper in system benches: gate signals in, emulated coil current out, comparator feedback back to the chip. It generalises the separate per-coil bridge and duty-meter models to CHANNELS instances with configurable rise/decay and saturation, decay-mode awareness, and shoot-through fault detection.

Parameters:
CHANNELS, 2, number of coils emulated
CURRENT_W, 13, signed current width (two's complement)
DUTY_W, 12, duty-meter window is 2**DUTY_W cycles; target width; must be <= CURRENT_W-1
RISE_STEP, 4, current increment per cycle while driven
DECAY_STEP, 1, slow-decay (brake) decrement per cycle; coast uses 2*DECAY_STEP
IMAX, 4000, saturation magnitude; must be < 2**(CURRENT_W-1)

Ports:
clock  in  1  bench clock
resetn  in  1  reset
low_1  in  CHANNELS  low-side gate, leg 1
high_1  in  CHANNELS  high-side gate, leg 1
low_2  in  CHANNELS  low-side gate, leg 2
high_2  in  CHANNELS  high-side gate, leg 2
polarity_invert  in  CHANNELS  swap POS/NEG per channel
pwm_ref  in  CHANNELS  PWM reference (analog_out) per channel
fault_clear  in  1  clears sticky faults
current  out  CHANNELS*CURRENT_W  signed coil current, channel i at [i*CURRENT_W +: CURRENT_W]
target  out  CHANNELS*DUTY_W  measured duty count per channel
cmp_out  out  CHANNELS  |current| >= target
fault  out  CHANNELS  sticky shoot-through flag
peak  out  CHANNELS*(CURRENT_W-1)  peak |current| per window (see Optional Feature)

Behaviour:
- Reset: resetn synchronous, active-low on clock. Reset values: current=0, target=0, cmp_out=1, fault=0, peak=0, window counter=0, high counters=0.
- Per-channel bridge decode, priority order:
  - SHOOT: (high_1&low_1)|(high_2&low_2).
  - POS: high_1&low_2, with low_1 and high_2 both low.
  - NEG: high_2&low_1, with high_1 and low_2 both low.
  - BRAKE: low_1&low_2.
  - COAST: all other combinations.
  - polarity_invert swaps POS and NEG.
- Current update on the same edge that samples the gates:
  - POS: +RISE_STEP, saturating at +IMAX.
  - NEG: -RISE_STEP, saturating at -IMAX.
  - BRAKE: toward 0 by DECAY_STEP.
  - COAST: toward 0 by 2*DECAY_STEP.
  - Decay never overshoots zero; it clamps to 0.
  - Reversal (POS while negative) ramps through zero at RISE_STEP with no clamp.
- Fault handling:
  - SHOOT sets fault on that edge and forces current to 0.
  - While fault=1, current is held at 0 regardless of gates.
  - fault_clear clears fault only if the channel is not in SHOOT that cycle; SHOOT wins over a simultaneous clear.
- Duty meter:
  - One shared DUTY_W-bit window counter free-runs 0..2**DUTY_W-1 and wraps.
  - Each channel has a high counter that counts cycles with pwm_ref=1 and saturates at 2**DUTY_W-1. So an all-high window gives 4095, not 0.
  - On the wrap edge, target is loaded with the count including that cycle's sample, and the high counter restarts at 0 (or 1 if pwm_ref=1).
  - target therefore updates once per window, with 1-cycle latency after the last sample.
- Comparator:
  - cmp_out is registered: (|current| low CURRENT_W-1 bits) >= zero-extended target. Inputs are the registered current and target, giving 1 cycle latency after current changes.
  - |−2**(CURRENT_W-1)| cannot occur because IMAX is bounded.
- Reset mid-window discards the partial count; the first target appears after a full window.

Optional Feature:
- Macro: COIL_EMULATOR_PEAK_TRACK_EN.
- Defined: peak[i] tracks max |current[i]| within the window and loads the final value on window wrap, alongside target. Running max restarts from the current |current|.
- Undefined: peak is tied to 0 and no tracking registers are built.

Decomposition:
- Package coil_emulator_pkg:
  - bridge state enum: BR_COAST, BR_POS, BR_NEG, BR_BRAKE, BR_SHOOT.
  - saturating add/decay helper functions.
  - parameter legality checks (DUTY_W <= CURRENT_W-1, IMAX bound).
- Sub-module coil_channel: decode, current integrator, fault, high counter, comparator, peak. Instantiated CHANNELS times by generate.
- Window counter stays in the top and is broadcast as a wrap strobe.

Test Plan:
- POS on ch0 (high_1=low_2=1) for 100 cycles from reset -> current0=400; ch1 untouched stays 0.
- POS for 1100 cycles -> current saturates at 4000 and stays. Then BRAKE (low_1=low_2=1) 400 cycles -> 3600. Then COAST 2000 cycles -> clamps to 0, never negative.
- high_1=low_1=1 for one cycle at current=400 -> fault=1 and current=0 next cycle; POS ignored while faulted. fault_clear with gates off -> fault=0 and ramp resumes. fault_clear concurrent with SHOOT -> fault stays 1.
- pwm_ref high 1024 of each 4096-cycle window -> target=1024 after first wrap. pwm_ref constantly high -> 4095. Reset asserted mid-window -> target=0 until a full window completes.
- target=1024: current 400 -> cmp_out=0; ramp NEG to -1100 -> cmp_out=1 one cycle after current reaches -1024. polarity_invert=1 with POS gates -> current goes negative.
- With COIL_EMULATOR_PEAK_TRACK_EN: ramp to 800, decay to 0 within a window -> peak=800 at wrap. Without the macro -> peak=0 throughout.
